// File: rtl/ps2_pkg.sv
// ps2_pkg: shared encodings for the PS/2 keyboard controller
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int ST_AVAIL = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_PERR  = 3;
    localparam int ST_FERR  = 4;
    localparam int ST_BUSY  = 5;
    localparam int ST_IE    = 7;

    localparam int CTL_FLUSH = 5;
    localparam int CTL_CLR   = 6;
    localparam int CTL_IE    = 7;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    // Odd parity over data plus parity bit is required; returns 1 on violation
    function automatic logic parity_err(input logic [7:0] d, input logic p);
        return ~^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: two-flop synchroniser plus glitch filter, filtered level and falling-edge pulse
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          fall_q;

    // Synchronise the asynchronous pin; an idle PS/2 line rests high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], line_i};
    end

    // Level follows only after FILTER_LEN consecutive samples disagree with it
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                fall_q  <= level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard receiver with scancode FIFO, CPU register window and level IRQ
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    inout  wire  [7:0] data_io,
    input  logic       r_i,
    input  logic       w_i,
    input  logic       addr_i,
    output logic       irq_o,
    input  logic       keyboard_clk_i,
    input  logic       keyboard_data_i
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    logic strobe;
    logic kdat;
    logic kclk_level_unused;
    logic kdat_fall_unused;

    rx_state_e     state_q;
    logic [7:0]    sr_q;
    logic [2:0]    bit_cnt_q;
    logic          par_bad_q;
    logic [TW-1:0] tmo_q;
    logic          push_q;
    logic          perr_set_q;
    logic          ferr_set_q;

    logic [1:0] r_sync_q;
    logic [1:0] w_sync_q;
    logic       r_prev_q;
    logic       w_prev_q;
    logic       addr_q;
    logic [7:0] wdata_q;
    logic       r_rise;
    logic       w_rise;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ie_q, ie_d;
    logic               ovr_q, ovr_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               irq_q;

    logic       avail;
    logic       full;
    logic       pop;
    logic       ctl_wr;
    logic       flush;
    logic       clr;
    logic       do_push;
    logic       do_pop;
    logic       ovr_set;
    logic [7:0] status;
    logic [7:0] rd_data;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .line_i  (keyboard_clk_i),
        .level_o (kclk_level_unused),
        .fall_o  (strobe)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .line_i  (keyboard_data_i),
        .level_o (kdat),
        .fall_o  (kdat_fall_unused)
    );

    // Frame receiver: advances on each keyboard clock fall, aborts stalled frames
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RX_IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            par_bad_q  <= 1'b0;
            tmo_q      <= '0;
            push_q     <= 1'b0;
            perr_set_q <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            perr_set_q <= 1'b0;
            ferr_set_q <= 1'b0;
            if (state_q == RX_IDLE || strobe) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_q      <= '0;
                state_q    <= RX_IDLE;
                ferr_set_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (strobe) begin
                case (state_q)
                    RX_IDLE: begin
                        if (!kdat) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    RX_DATA: begin
                        sr_q      <= {kdat, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_bad_q <= parity_err(sr_q, kdat);
                        state_q   <= RX_STOP;
                    end
                    RX_STOP: begin
                        push_q     <= kdat & ~par_bad_q;
                        ferr_set_q <= ~kdat;
                        perr_set_q <= par_bad_q;
                        state_q    <= RX_IDLE;
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    // Bus strobe synchronisers; address and write data captured while the strobe is low
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync_q <= 2'b11;
            w_sync_q <= 2'b11;
            r_prev_q <= 1'b1;
            w_prev_q <= 1'b1;
            addr_q   <= 1'b0;
            wdata_q  <= '0;
        end else begin
            r_sync_q <= {r_sync_q[0], r_i};
            w_sync_q <= {w_sync_q[0], w_i};
            r_prev_q <= r_sync_q[1];
            w_prev_q <= w_sync_q[1];
            if (!r_sync_q[1] || !w_sync_q[1]) addr_q <= addr_i;
            if (!w_sync_q[1]) wdata_q <= data_io;
        end
    end

    assign r_rise  = r_sync_q[1] & ~r_prev_q;
    assign w_rise  = w_sync_q[1] & ~w_prev_q;
    assign avail   = count_q != '0;
    assign full    = count_q == CW'(DEPTH);
    assign pop     = r_rise & (addr_q == REG_DATA) & avail;
    assign ctl_wr  = w_rise & (addr_q == REG_STAT);
    assign flush   = ctl_wr & wdata_q[CTL_FLUSH];
    assign clr     = ctl_wr & wdata_q[CTL_CLR];
    assign do_push = push_q & (~full | pop) & ~flush;
    assign do_pop  = pop & ~flush;
    assign ovr_set = push_q & full & ~pop & ~flush;

    // FIFO and status next state: flush wins over push/pop, error set wins over clear
    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + FIFO_AW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + FIFO_AW'(do_pop);
        count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
        ie_d     = ctl_wr ? wdata_q[CTL_IE] : ie_q;
        ovr_d    = ovr_set | (ovr_q & ~clr);
        perr_d   = perr_set_q | (perr_q & ~clr);
        ferr_d   = ferr_set_q | (ferr_q & ~clr);
    end

    // Register file state and the registered interrupt line
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ie_q     <= 1'b0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ie_q     <= ie_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            irq_q    <= ie_q & (avail | ovr_q | perr_q | ferr_q);
        end
    end

    // Scancode storage needs no reset; count guards every read
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= sr_q;
    end

    // Read mux follows ADDR directly while R is low
    always_comb begin
        status           = 8'h00;
        status[ST_AVAIL] = avail;
        status[ST_FULL]  = full;
        status[ST_OVR]   = ovr_q;
        status[ST_PERR]  = perr_q;
        status[ST_FERR]  = ferr_q;
        status[ST_BUSY]  = state_q != RX_IDLE;
        status[ST_IE]    = ie_q;
        rd_data          = (addr_i == REG_STAT) ? status : (avail ? mem_q[rd_ptr_q] : 8'h00);
    end

    assign data_io = r_i ? 8'hzz : rd_data;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed and randomized frames checked against a frame-level model
module tb_ps2_kbd_ctrl;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_n = 1'b1;
    logic w_n = 1'b1;
    logic addr = 1'b0;
    logic kclk = 1'b1;
    logic kdat = 1'b1;
    logic tb_oe = 1'b0;
    logic [7:0] tb_wd = 8'h00;
    wire  [7:0] data_bus;
    wire        irq;

    assign data_bus = tb_oe ? tb_wd : 8'hzz;

    ps2_kbd_ctrl dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .data_io         (data_bus),
        .r_i             (r_n),
        .w_i             (w_n),
        .addr_i          (addr),
        .irq_o           (irq),
        .keyboard_clk_i  (kclk),
        .keyboard_data_i (kdat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    bit m_ie, m_ovr, m_perr, m_ferr;
    bit chk_en = 1'b0;

    function automatic logic [7:0] m_status();
        return {m_ie, 1'b0, 1'b0, m_ferr, m_perr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
    endfunction

    function automatic logic m_irq();
        return m_ie && (mq.size() != 0 || m_ovr || m_perr || m_ferr);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %02h required %02h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("irq_vs_model", {7'd0, irq}, {7'd0, m_irq()});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        tick(8);
        chk_en = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        kdat = b;
        tick(10);
        kclk = 1'b0;
        tick(20);
        kclk = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        chk_en = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        kdat = 1'b1;
        tick(20);
        if (bad_par) m_perr = 1'b1;
        if (bad_stop) m_ferr = 1'b1;
        if (!bad_par && !bad_stop) begin
            if (mq.size() == DEPTH) m_ovr = 1'b1;
            else mq.push_back(d);
        end
        settle();
    endtask

    task automatic bus_read(input logic a, input bit use_lit, input logic [7:0] lit, input string name);
        logic [7:0] exp;
        chk_en = 1'b0;
        exp = use_lit ? lit : (a ? m_status() : (mq.size() != 0 ? mq[0] : 8'h00));
        addr = a;
        r_n = 1'b0;
        tick(4);
        check(name, data_bus, exp);
        r_n = 1'b1;
        tick(6);
        if (!a && rst_n && mq.size() != 0) void'(mq.pop_front());
        if (rst_n) settle();
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        chk_en = 1'b0;
        addr = a;
        tb_wd = d;
        tb_oe = 1'b1;
        w_n = 1'b0;
        tick(4);
        w_n = 1'b1;
        tick(3);
        tb_oe = 1'b0;
        tick(3);
        if (a) begin
            m_ie = d[7];
            if (d[6]) begin
                m_ovr = 1'b0;
                m_perr = 1'b0;
                m_ferr = 1'b0;
            end
            if (d[5]) mq.delete();
        end
        settle();
    endtask

    task automatic model_reset();
        mq.delete();
        m_ie = 1'b0;
        m_ovr = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int op;
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("reset_irq", {7'd0, irq}, 8'h00);
        bus_read(1'b1, 1, 8'h00, "reset_status");
        bus_read(1'b0, 1, 8'h00, "reset_data");

        // 1: single good frame with interrupts enabled
        bus_write(1'b1, 8'h80);
        send_frame(8'h1C, 0, 0);
        check("t1_irq_high", {7'd0, irq}, 8'h01);
        bus_read(1'b1, 1, 8'h81, "t1_status");
        bus_read(1'b0, 1, 8'h1C, "t1_data");
        check("t1_irq_low", {7'd0, irq}, 8'h00);
        bus_read(1'b1, 1, 8'h80, "t1_status_after");

        // 2: overflow a depth-8 FIFO
        bus_write(1'b1, 8'h00);
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
        bus_read(1'b1, 1, 8'h07, "t2_status_full_ovr");
        for (int i = 1; i <= 8; i++) bus_read(1'b0, 1, 8'(i), "t2_data_order");
        bus_read(1'b0, 1, 8'h00, "t2_data_empty");
        bus_read(1'b1, 1, 8'h04, "t2_status_after");

        // 3: parity error, then clear
        bus_write(1'b1, 8'h40);
        send_frame(8'h55, 1, 0);
        bus_read(1'b1, 1, 8'h08, "t3_status_perr");
        bus_write(1'b1, 8'h40);
        bus_read(1'b1, 1, 8'h00, "t3_status_cleared");

        // 4: stalled frame times out, then a good frame
        chk_en = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        kdat = 1'b1;
        tick(2100);
        m_ferr = 1'b1;
        settle();
        bus_read(1'b1, 1, 8'h10, "t4_status_ferr");
        send_frame(8'hF0, 0, 0);
        bus_read(1'b1, 1, 8'h11, "t4_status_after_frame");
        bus_read(1'b0, 1, 8'hF0, "t4_data");
        bus_write(1'b1, 8'h40);

        // 5: single-sample glitches on the keyboard clock
        for (int i = 0; i < 5; i++) begin
            kclk = 1'b0;
            tick(1);
            kclk = 1'b1;
            tick(7);
        end
        bus_read(1'b1, 1, 8'h00, "t5_status");
        bus_read(1'b0, 1, 8'h00, "t5_data");

        // 6: flush lands on the same cycle as a stop-bit push
        send_frame(8'hA1, 0, 0);
        send_frame(8'hA2, 0, 0);
        send_frame(8'hA3, 0, 0);
        bus_read(1'b1, 1, 8'h01, "t6_status_three");
        chk_en = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_bit(1'b1);
        kdat = 1'b1;
        addr = 1'b1;
        tb_wd = 8'h20;
        tb_oe = 1'b1;
        w_n = 1'b0;
        tick(10);
        kclk = 1'b0;
        tick(5);
        w_n = 1'b1;
        tick(3);
        tb_oe = 1'b0;
        tick(12);
        kclk = 1'b1;
        tick(30);
        mq.delete();
        m_ie = 1'b0;
        settle();
        bus_read(1'b1, 1, 8'h00, "t6_status_flushed");

        // 6b: reset mid-frame
        bus_write(1'b1, 8'h80);
        send_frame(8'h3C, 0, 0);
        check("t6_irq_before_reset", {7'd0, irq}, 8'h01);
        chk_en = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        kdat = 1'b0;
        tick(10);
        kclk = 1'b0;
        tick(3);
        rst_n = 1'b0;
        model_reset();
        tick(2);
        check("t6_irq_in_reset", {7'd0, irq}, 8'h00);
        kclk = 1'b1;
        kdat = 1'b1;
        bus_read(1'b1, 1, 8'h00, "t6_status_in_reset");
        bus_read(1'b0, 1, 8'h00, "t6_data_in_reset");
        rst_n = 1'b1;
        tick(10);
        settle();
        send_frame(8'h3A, 0, 0);
        bus_read(1'b1, 1, 8'h01, "t6_status_recovered");
        bus_read(1'b0, 1, 8'h3A, "t6_data_recovered");

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 11));
            if (op <= 4) begin
                d = 8'($urandom);
                send_frame(d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end else if (op <= 7) begin
                bus_read(1'b0, 0, 8'h00, "rnd_data");
            end else if (op <= 9) begin
                bus_read(1'b1, 0, 8'h00, "rnd_status");
            end else if (op == 10) begin
                d = 8'($urandom);
                d[6] = $urandom_range(0, 2) == 0;
                d[5] = $urandom_range(0, 4) == 0;
                bus_write(1'b1, d);
            end else begin
                bus_write(1'b0, 8'($urandom));
            end
        end
        bus_read(1'b1, 0, 8'h00, "rnd_final_status");
        while (mq.size() != 0) bus_read(1'b0, 0, 8'h00, "rnd_drain");
        bus_read(1'b0, 1, 8'h00, "rnd_drained_empty");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
